// File: rtl/uart_defs.sv
// Shared UART definitions: FSM encoding, frame layout, parity select and bit timing.
package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_t;

    // Frame layout: 1 start, 8 data (LSB first), 1 parity, 1 stop
    localparam int DATA_BITS   = 8;
    localparam int PARITY_BITS = 1;
    localparam int STOP_BITS   = 1;

    // Parity select values for the PARITY parameter
    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Transmitter and receiver both derive their bit period from this
    function automatic int calc_clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

    // Parity bit that makes data plus parity even (odd = 0) or odd (odd = 1)
    function automatic logic parity_of(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO in front of the transmitter; read data is shown
// combinationally at the head so the FSM can load it on the pop edge.
module uart_tx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    // A push on a full FIFO is dropped even when a pop happens on the same edge
    assign full     = (count == CNT_FULL);
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign data_out = mem[rd_ptr];

    // Storage array: no reset, entries are only meaningful below the count
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Pointers and occupancy; power-of-2 depth lets the pointers wrap naturally
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: FIFO-buffered bytes sent as start, 8 data LSB first,
// parity and stop bits. Line outputs are registered from the current state,
// so the line trails the FSM state by one cycle.
module uart_tx
    import uart_defs::*;
#(
    parameter int CLK_FREQ   = 6000000,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY     = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic ODD        = (PARITY == PARITY_ODD);

    tx_state_t      state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;
    logic           par_bit;
    logic [7:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;
    logic           bit_end;

    assign tx_ready = !fifo_full;
    assign bit_end  = (baud_cnt == CNT_LAST);
    // Pop whenever the FSM is about to start a frame: from idle, or straight out of a stop bit
    assign fifo_pop = !fifo_empty && ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));

    uart_tx_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .reset    (reset),
        .push     (tx_valid),
        .pop      (fifo_pop),
        .data_in  (data_in),
        .data_out (fifo_dout),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Frame sequencer with registered line, busy and done outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= 1'b1;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            tx_busy <= (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    if (!fifo_empty) begin
                        shift   <= fifo_dout;
                        par_bit <= parity_of(fifo_dout, ODD);
                        state   <= ST_START;
                    end
                end
                ST_START: begin
                    tx <= 1'b0;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= ST_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_DATA: begin
                    tx <= shift[bit_idx];
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= ST_PARITY;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_PARITY: begin
                    tx <= par_bit;
                    if (bit_end) begin
                        baud_cnt <= '0;
                        state    <= ST_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                ST_STOP: begin
                    tx <= 1'b1;
                    if (bit_end) begin
                        tx_done  <= 1'b1;
                        baud_cnt <= '0;
                        if (!fifo_empty) begin
                            shift   <= fifo_dout;
                            par_bit <= parity_of(fifo_dout, ODD);
                            state   <= ST_START;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    tx       <= 1'b1;
                    baud_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a fast even-parity instance (10 clocks per bit) and a
// default-rate odd-parity instance, checked against a frame-level line model.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       e_reset, e_valid, e_ready, e_tx, e_busy, e_done;
    logic [7:0] e_data;
    logic       o_reset, o_valid, o_ready, o_tx, o_busy, o_done;
    logic [7:0] o_data;

    int tests = 0;
    int fails = 0;

    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY(0), .FIFO_DEPTH(4)) u_even (
        .clk(clk), .reset(e_reset), .data_in(e_data), .tx_valid(e_valid),
        .tx_ready(e_ready), .tx(e_tx), .tx_busy(e_busy), .tx_done(e_done)
    );

    uart_tx #(.CLK_FREQ(6000000), .BAUD_RATE(9600), .PARITY(1), .FIFO_DEPTH(4)) u_odd (
        .clk(clk), .reset(o_reset), .data_in(o_data), .tx_valid(o_valid),
        .tx_ready(o_ready), .tx(o_tx), .tx_busy(o_busy), .tx_done(o_done)
    );

    function automatic logic tx_of(input int sel);
        return (sel == 0) ? e_tx : o_tx;
    endfunction

    function automatic logic busy_of(input int sel);
        return (sel == 0) ? e_busy : o_busy;
    endfunction

    function automatic logic done_of(input int sel);
        return (sel == 0) ? e_done : o_done;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input int sel, input logic [7:0] b);
        if (sel == 0) begin
            e_data = b; e_valid = 1'b1;
        end else begin
            o_data = b; o_valid = 1'b1;
        end
        @(negedge clk);
        e_valid = 1'b0;
        o_valid = 1'b0;
    endtask

    // Waits for a start bit, then records the whole 11-bit frame cycle by cycle
    task automatic recv_frame(input int sel, input int cpb, input int max_wait,
                              output logic [10:0] bits, output int waited, output int unstable,
                              output int busy_low, output int done_bad, output logic to);
        logic samp [];
        waited = 0; unstable = 0; busy_low = 0; done_bad = 0; to = 1'b0; bits = '0;
        while (tx_of(sel) !== 1'b0) begin
            if (waited >= max_wait) begin
                to = 1'b1;
                return;
            end
            @(negedge clk);
            waited++;
        end
        samp = new[11 * cpb];
        for (int i = 0; i < 11 * cpb; i++) begin
            samp[i] = tx_of(sel);
            if (busy_of(sel) !== 1'b1) busy_low++;
            if (done_of(sel) !== (i == 11 * cpb - 1)) done_bad++;
            @(negedge clk);
        end
        for (int b = 0; b < 11; b++) begin
            bits[b] = samp[b * cpb + cpb / 2];
            for (int c = 0; c < cpb; c++) begin
                if (samp[b * cpb + c] !== bits[b]) unstable++;
            end
        end
    endtask

    task automatic judge(input string tag, input logic [10:0] bits, input logic [7:0] exp_byte,
                         input logic odd, input int waited, input int exp_wait,
                         input int unstable, input int busy_low, input int done_bad);
        logic [10:0] exp_bits;
        exp_bits = {1'b1, (^exp_byte) ^ odd, exp_byte, 1'b0};
        check({tag, "_line"}, 32'(bits), 32'(exp_bits));
        check({tag, "_parity_err"}, 32'((^bits[9:1]) ^ odd), 32'd0);
        check({tag, "_bit_len"}, unstable, 0);
        check({tag, "_busy"}, busy_low, 0);
        check({tag, "_done"}, done_bad, 0);
        if (exp_wait >= 0) check({tag, "_gap"}, waited, exp_wait);
    endtask

    task automatic check_frame(input string tag, input int sel, input int cpb, input logic [7:0] exp_byte,
                               input logic odd, input int max_wait, input int exp_wait,
                               output logic [10:0] bits);
        int waited, unstable, busy_low, done_bad;
        logic to;
        recv_frame(sel, cpb, max_wait, bits, waited, unstable, busy_low, done_bad, to);
        check({tag, "_start"}, 32'(to), 32'd0);
        if (!to) judge(tag, bits, exp_byte, odd, waited, exp_wait, unstable, busy_low, done_bad);
    endtask

    task automatic check_idle(input string tag, input int sel);
        check({tag, "_idle_tx"}, 32'(tx_of(sel)), 32'd1);
        check({tag, "_idle_busy"}, 32'(busy_of(sel)), 32'd0);
        check({tag, "_idle_done"}, 32'(done_of(sel)), 32'd0);
    endtask

    task automatic fill_test();
        logic [10:0] bits;
        push_byte(0, 8'hA0);
        fork
            begin
                int idx;
                int guard;
                logic rdy;
                idx = 1; guard = 0;
                e_data = 8'hA1; e_valid = 1'b1;
                while (idx <= 5 && guard < 1000) begin
                    rdy = e_ready;
                    @(negedge clk);
                    guard++;
                    if (rdy) begin
                        idx++;
                        if (idx <= 4) check("fill_ready_open", 32'(e_ready), 32'd1);
                        else if (idx == 5) check("fill_ready_full", 32'(e_ready), 32'd0);
                        e_data = 8'(8'hA0 + idx);
                    end
                end
                e_valid = 1'b0;
                check("fill_all_accepted", idx, 6);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    check_frame($sformatf("fill%0d", i), 0, 10, 8'(8'hA0 + i), 1'b0, 300,
                                (i == 0) ? 2 : 0, bits);
                end
            end
        join
        check_idle("fill_end", 0);
    endtask

    task automatic reset_test();
        int bad;
        push_byte(0, 8'hC3);
        push_byte(0, 8'h3C);
        push_byte(0, 8'h96);
        repeat (45) @(negedge clk);
        check("rst_mid_bit3", 32'(e_tx), 32'd0);
        check("rst_mid_busy", 32'(e_busy), 32'd1);
        e_reset = 1'b1; e_valid = 1'b1; e_data = 8'h77;
        @(negedge clk);
        check("rst_tx", 32'(e_tx), 32'd1);
        check("rst_busy", 32'(e_busy), 32'd0);
        check("rst_done", 32'(e_done), 32'd0);
        e_reset = 1'b0; e_valid = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 32'(e_ready), 32'd1);
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            if (e_tx !== 1'b1 || e_busy !== 1'b0) bad++;
            @(negedge clk);
        end
        check("rst_no_more_frames", bad, 0);
    endtask

    task automatic random_test(input int n);
        fork
            begin
                for (int i = 0; i < n; i++) begin
                    int gap;
                    int guard;
                    logic [7:0] b;
                    gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 150)) : 0;
                    repeat (gap) @(negedge clk);
                    b = 8'($urandom);
                    e_data = b; e_valid = 1'b1;
                    guard = 0;
                    while (e_ready !== 1'b1 && guard < 1000) begin
                        @(negedge clk);
                        guard++;
                    end
                    @(negedge clk);
                    sb_q.push_back(b);
                    e_valid = 1'b0;
                end
            end
            begin
                for (int i = 0; i < n; i++) begin
                    logic [10:0] bits;
                    int waited, unstable, busy_low, done_bad;
                    logic to;
                    logic [7:0] exp_byte;
                    recv_frame(0, 10, 500, bits, waited, unstable, busy_low, done_bad, to);
                    check("rand_start", 32'(to), 32'd0);
                    if (to) break;
                    check("rand_sent_before_seen", 32'(sb_q.size() != 0), 32'd1);
                    exp_byte = (sb_q.size() != 0) ? sb_q.pop_front() : 8'h00;
                    judge($sformatf("rand%0d", i), bits, exp_byte, 1'b0, waited, -1,
                          unstable, busy_low, done_bad);
                end
            end
        join
        check("rand_scoreboard_empty", sb_q.size(), 0);
        check_idle("rand_end", 0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [10:0] bits;
        e_reset = 1'b1; e_valid = 1'b0; e_data = 8'h00;
        o_reset = 1'b1; o_valid = 1'b0; o_data = 8'h00;
        repeat (3) @(negedge clk);
        e_reset = 1'b0; o_reset = 1'b0;
        @(negedge clk);
        check("reset_ready", 32'(e_ready), 32'd1);
        check_idle("reset", 0);
        check("reset_odd_ready", 32'(o_ready), 32'd1);
        check_idle("reset_odd", 1);

        // 0x55 even parity: exact line pattern and two-cycle start latency
        push_byte(0, 8'h55);
        check_frame("even55", 0, 10, 8'h55, 1'b0, 10, 2, bits);
        check("even55_sequence", 32'(bits), 32'(11'b10010101010));
        check_idle("even55", 0);

        push_byte(0, 8'h01);
        check_frame("even01", 0, 10, 8'h01, 1'b0, 10, 2, bits);
        check("even01_parity_bit", 32'(bits[9]), 32'd1);
        check_idle("even01", 0);

        // Odd parity at the default 625 clocks per bit
        push_byte(1, 8'h01);
        check_frame("odd01", 1, 625, 8'h01, 1'b1, 10, 2, bits);
        check("odd01_parity_bit", 32'(bits[9]), 32'd0);
        check_idle("odd01", 1);

        fill_test();
        reset_test();
        random_test(256);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
